// File: rtl/hall_lighting_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hall_lighting_pkg
//  Description : Shared types and default timing constants for the hall
//                doorway beam direction decoder and its testbench.
//  Revision    : 1.0 - initial release
// ============================================================================
package hall_lighting_pkg;

  // Crossing-tracker states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ENT1     = 3'd1,
    ST_ENT2     = 3'd2,
    ST_ENT3     = 3'd3,
    ST_EXT1     = 3'd4,
    ST_EXT2     = 3'd5,
    ST_EXT3     = 3'd6,
    ST_WAIT_CLR = 3'd7
  } beam_state_t;

  // Debounced beam pair encoding: {outer, inner}
  localparam logic [1:0] BEAMS_NONE  = 2'b00;
  localparam logic [1:0] BEAMS_INNER = 2'b01;
  localparam logic [1:0] BEAMS_OUTER = 2'b10;
  localparam logic [1:0] BEAMS_BOTH  = 2'b11;

  // Defaults for a 100 MHz clock: 5 ms debounce, 3 s timeout, 10 s stuck
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int DEFAULT_TIMEOUT_CYCLES  = 300000000;
  localparam int DEFAULT_STUCK_CYCLES    = 1000000000;

endpackage : hall_lighting_pkg
`default_nettype wire

// File: rtl/beam_direction_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : beam_direction_decoder_if
//  Description : Entry/exit event interface between the doorway decoder
//                (master, producer) and the occupancy counter (slave).
//                The stuck flag is present only when STUCK_DETECT_EN is
//                defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface beam_direction_decoder_if;

  logic entry_sensor;
  logic exit_sensor;
  logic busy;
`ifdef STUCK_DETECT_EN
  logic stuck;
`endif

`ifdef STUCK_DETECT_EN
  modport master (output entry_sensor, output exit_sensor, output busy, output stuck);
  modport slave  (input  entry_sensor, input  exit_sensor, input  busy, input  stuck);
`else
  modport master (output entry_sensor, output exit_sensor, output busy);
  modport slave  (input  entry_sensor, input  exit_sensor, input  busy);
`endif

endinterface : beam_direction_decoder_if
`default_nettype wire

// File: rtl/beam_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : beam_debounce
//  Description : Two-flop synchroniser followed by a debouncer. The output
//                level follows the synchronised input only after it has
//                differed for DEBOUNCE_CYCLES consecutive cycles; any return
//                to the current level restarts the count.
//  Revision    : 1.0 - initial release
// ============================================================================
module beam_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic beam_i,
  output logic      level_o
);

  localparam int               CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q;
  logic             sync_q;
  logic             level_q;
  logic             level_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Bring the asynchronous beam input into the clock domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= beam_i;
      sync_q <= meta_q;
    end
  end

  // Count consecutive disagreeing cycles; flip the level on the last one
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debounce state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule : beam_debounce
`default_nettype wire

// File: rtl/beam_direction_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : beam_direction_decoder
//  Description : Turns the outer/inner doorway beam-break inputs into
//                one-cycle entry/exit pulses. Each beam is synchronised and
//                debounced, then a crossing-order FSM with a dwell timeout
//                emits exactly one pulse per completed crossing.
//                Optional feature macro: STUCK_DETECT_EN adds per-beam
//                blocked-time counters and a sticky stuck flag that forces
//                the FSM into WAIT_CLR.
//  Revision    : 1.0 - initial release
// ============================================================================
module beam_direction_decoder
  import hall_lighting_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES,
  parameter int STUCK_CYCLES    = DEFAULT_STUCK_CYCLES
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  input  wire logic                 beam_outer,
  input  wire logic                 beam_inner,
  beam_direction_decoder_if.master  evt_o
);

  localparam int            DWELL_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(TIMEOUT_CYCLES);

  // Reject configurations that would make a counter meaningless
  generate
    if (DEBOUNCE_CYCLES < 1 || TIMEOUT_CYCLES < 1 || STUCK_CYCLES < 1) begin : g_param_check
      $error("beam_direction_decoder: cycle parameters must be at least 1");
    end
  endgenerate

  logic               outer_lvl;
  logic               inner_lvl;
  logic [1:0]         beams;
  logic               stuck_act;

  beam_state_t        state_q;
  beam_state_t        state_d;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] dwell_d;
  logic               entry_q;
  logic               entry_d;
  logic               exit_q;
  logic               exit_d;
  logic               busy_q;

  beam_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_outer (
    .clk     (clk),
    .rst_n   (rst_n),
    .beam_i  (beam_outer),
    .level_o (outer_lvl)
  );

  beam_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_inner (
    .clk     (clk),
    .rst_n   (rst_n),
    .beam_i  (beam_inner),
    .level_o (inner_lvl)
  );

  assign beams = {outer_lvl, inner_lvl};

`ifdef STUCK_DETECT_EN
  localparam int                 STUCK_W   = $clog2(STUCK_CYCLES + 1);
  localparam logic [STUCK_W-1:0] STUCK_MAX = STUCK_W'(STUCK_CYCLES);

  logic [STUCK_W-1:0] outer_blk_q;
  logic [STUCK_W-1:0] inner_blk_q;
  logic               stuck_q;

  // Measure continuous blocked time per beam; latch the stuck flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outer_blk_q <= '0;
      inner_blk_q <= '0;
      stuck_q     <= 1'b0;
    end else begin
      if (!outer_lvl) begin
        outer_blk_q <= '0;
      end else if (outer_blk_q != STUCK_MAX) begin
        outer_blk_q <= outer_blk_q + 1'b1;
      end
      if (!inner_lvl) begin
        inner_blk_q <= '0;
      end else if (inner_blk_q != STUCK_MAX) begin
        inner_blk_q <= inner_blk_q + 1'b1;
      end
      if (outer_blk_q == STUCK_MAX || inner_blk_q == STUCK_MAX) begin
        stuck_q <= 1'b1;
      end
    end
  end

  assign stuck_act   = stuck_q;
  assign evt_o.stuck = stuck_q;
`else
  assign stuck_act = 1'b0;
`endif

  // Crossing-order next state, completion pulses and dwell counter
  always_comb begin
    state_d = state_q;
    entry_d = 1'b0;
    exit_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (beams == BEAMS_OUTER)      state_d = ST_ENT1;
        else if (beams == BEAMS_INNER) state_d = ST_EXT1;
        else if (beams == BEAMS_BOTH)  state_d = ST_WAIT_CLR;
      end
      ST_ENT1: begin
        if (beams == BEAMS_BOTH)       state_d = ST_ENT2;
        else if (beams == BEAMS_NONE)  state_d = ST_IDLE;
      end
      ST_ENT2: begin
        if (beams == BEAMS_INNER)      state_d = ST_ENT3;
        else if (beams == BEAMS_OUTER) state_d = ST_ENT1;
        else if (beams == BEAMS_NONE)  state_d = ST_IDLE;
      end
      ST_ENT3: begin
        if (beams == BEAMS_NONE) begin
          state_d = ST_IDLE;
          entry_d = 1'b1;
        end else if (beams == BEAMS_BOTH) begin
          state_d = ST_ENT2;
        end else if (beams == BEAMS_OUTER) begin
          state_d = ST_WAIT_CLR;
        end
      end
      ST_EXT1: begin
        if (beams == BEAMS_BOTH)       state_d = ST_EXT2;
        else if (beams == BEAMS_NONE)  state_d = ST_IDLE;
      end
      ST_EXT2: begin
        if (beams == BEAMS_OUTER)      state_d = ST_EXT3;
        else if (beams == BEAMS_INNER) state_d = ST_EXT1;
        else if (beams == BEAMS_NONE)  state_d = ST_IDLE;
      end
      ST_EXT3: begin
        if (beams == BEAMS_NONE) begin
          state_d = ST_IDLE;
          exit_d  = 1'b1;
        end else if (beams == BEAMS_BOTH) begin
          state_d = ST_EXT2;
        end else if (beams == BEAMS_INNER) begin
          state_d = ST_WAIT_CLR;
        end
      end
      ST_WAIT_CLR: begin
        if (beams == BEAMS_NONE)       state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A stalled crossing is abandoned; the timeout wins over any move
    if (state_q != ST_IDLE && state_q != ST_WAIT_CLR && dwell_q == DWELL_MAX) begin
      state_d = ST_WAIT_CLR;
      entry_d = 1'b0;
      exit_d  = 1'b0;
    end

    // A stuck beam parks the FSM until both beams are clear, silently
    if (stuck_act) begin
      state_d = (beams == BEAMS_NONE) ? ST_IDLE : ST_WAIT_CLR;
      entry_d = 1'b0;
      exit_d  = 1'b0;
    end

    if (state_d != state_q) begin
      dwell_d = '0;
    end else if (dwell_q == DWELL_MAX) begin
      dwell_d = dwell_q;
    end else begin
      dwell_d = dwell_q + 1'b1;
    end
  end

  // FSM state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dwell_q <= '0;
      entry_q <= 1'b0;
      exit_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      entry_q <= entry_d;
      exit_q  <= exit_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign evt_o.entry_sensor = entry_q;
  assign evt_o.exit_sensor  = exit_q;
  assign evt_o.busy         = busy_q;

endmodule : beam_direction_decoder
`default_nettype wire

// File: tb/tb_beam_direction_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_beam_direction_decoder
//  Description : Directed testbench for beam_direction_decoder with
//                DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=100, STUCK_CYCLES=300.
//                Stuck-beam scenario is compiled in with STUCK_DETECT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_beam_direction_decoder;

  localparam int DEB = 4;
  localparam int TMO = 100;
  localparam int STK = 300;

  logic clk        = 1'b0;
  logic rst_n      = 1'b0;
  logic beam_outer = 1'b0;
  logic beam_inner = 1'b0;

  int n_vec     = 0;
  int n_err     = 0;
  int cyc       = 0;
  int n_entry   = 0;
  int n_exit    = 0;
  int n_viol    = 0;
  int entry_cyc = -1;
  logic prev_pulse = 1'b0;

  int e0;
  int x0;
  int rel_cyc;

  always #5 clk = ~clk;

  beam_direction_decoder_if evt();

  beam_direction_decoder #(
    .DEBOUNCE_CYCLES (DEB),
    .TIMEOUT_CYCLES  (TMO),
    .STUCK_CYCLES    (STK)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .beam_outer (beam_outer),
    .beam_inner (beam_inner),
    .evt_o      (evt)
  );

  // Cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: counts pulses and exclusivity / back-to-back violations
  always @(negedge clk) begin
    if (evt.entry_sensor === 1'b1) begin
      n_entry   <= n_entry + 1;
      entry_cyc <= cyc;
    end
    if (evt.exit_sensor === 1'b1) n_exit <= n_exit + 1;
    if (evt.entry_sensor === 1'b1 && evt.exit_sensor === 1'b1) n_viol <= n_viol + 1;
    if (prev_pulse && (evt.entry_sensor === 1'b1 || evt.exit_sensor === 1'b1)) n_viol <= n_viol + 1;
    prev_pulse <= (evt.entry_sensor === 1'b1) || (evt.exit_sensor === 1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive both beams, then hold for n cycles; returns 1 time unit after an edge
  task automatic hold(input logic o, input logic i, input int n);
    beam_outer = o;
    beam_inner = i;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    e0 = n_entry;
    x0 = n_exit;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_entry", 32'(evt.entry_sensor), 32'd0);
    chk("rst_exit",  32'(evt.exit_sensor),  32'd0);
    chk("rst_busy",  32'(evt.busy),         32'd0);
`ifdef STUCK_DETECT_EN
    chk("rst_stuck", 32'(evt.stuck),        32'd0);
`endif
    rst_n = 1'b1;
    hold(0, 0, 5);

    // Clean entry with release-to-pulse latency
    snap();
    hold(1, 0, 10);
    chk("entry_busy_hi", 32'(evt.busy), 32'd1);
    hold(1, 1, 10);
    hold(0, 1, 10);
    rel_cyc = cyc;
    hold(0, 0, 12);
    chk("entry_cnt",     32'(n_entry - e0), 32'd1);
    chk("entry_no_exit", 32'(n_exit - x0),  32'd0);
    chk("entry_latency", 32'(entry_cyc - rel_cyc), 32'd7);
    chk("entry_busy_lo", 32'(evt.busy), 32'd0);

    // Clean exit with a 2-cycle glitch on the inner beam
    snap();
    hold(0, 1, 5);
    hold(0, 0, 2);
    hold(0, 1, 5);
    hold(1, 1, 10);
    hold(1, 0, 10);
    hold(0, 0, 12);
    chk("exit_cnt",      32'(n_exit - x0),  32'd1);
    chk("exit_no_entry", 32'(n_entry - e0), 32'd0);
    chk("exit_busy_lo",  32'(evt.busy), 32'd0);

    // Backtrack: outer, both, outer-only, clear
    snap();
    hold(1, 0, 10);
    hold(1, 1, 10);
    hold(1, 0, 10);
    chk("back_busy_hi", 32'(evt.busy), 32'd1);
    hold(0, 0, 12);
    chk("back_pulses",  32'((n_entry - e0) + (n_exit - x0)), 32'd0);
    chk("back_busy_lo", 32'(evt.busy), 32'd0);

    // Simultaneous block is ambiguous even if a valid-looking tail follows
    snap();
    hold(1, 1, 10);
    chk("simul_busy_hi", 32'(evt.busy), 32'd1);
    hold(0, 1, 10);
    hold(0, 0, 12);
    chk("simul_pulses",  32'((n_entry - e0) + (n_exit - x0)), 32'd0);
    chk("simul_busy_lo", 32'(evt.busy), 32'd0);

    // Long but sub-timeout dwell in ENT1 still completes
    snap();
    hold(1, 0, 98);
    hold(1, 1, 10);
    hold(0, 1, 10);
    hold(0, 0, 12);
    chk("slow_entry_cnt", 32'(n_entry - e0), 32'd1);

    // Timeout in ENT1 aborts an otherwise valid entry
    snap();
    hold(1, 0, 150);
    chk("tmo_busy_hi", 32'(evt.busy), 32'd1);
    hold(1, 1, 10);
    hold(0, 1, 10);
    chk("tmo_busy_wait", 32'(evt.busy), 32'd1);
    hold(0, 0, 12);
    chk("tmo_pulses",  32'((n_entry - e0) + (n_exit - x0)), 32'd0);
    chk("tmo_busy_lo", 32'(evt.busy), 32'd0);

    // Reset in ENT2 discards the crossing
    snap();
    hold(1, 0, 10);
    hold(1, 1, 10);
    chk("rst2_busy_pre", 32'(evt.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst2_busy",  32'(evt.busy),         32'd0);
    chk("rst2_entry", 32'(evt.entry_sensor), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold(1, 1, 10);
    hold(0, 1, 10);
    hold(0, 0, 12);
    chk("rst2_pulses",  32'((n_entry - e0) + (n_exit - x0)), 32'd0);
    chk("rst2_busy_lo", 32'(evt.busy), 32'd0);

`ifdef STUCK_DETECT_EN
    // Stuck inner beam sets the sticky flag and suppresses later crossings
    snap();
    hold(0, 1, 400);
    chk("stuck_set",  32'(evt.stuck), 32'd1);
    hold(0, 0, 12);
    chk("stuck_hold", 32'(evt.stuck), 32'd1);
    chk("stuck_idle", 32'(evt.busy),  32'd0);
    hold(1, 0, 10);
    hold(1, 1, 10);
    hold(0, 1, 10);
    hold(0, 0, 12);
    chk("stuck_pulses", 32'((n_entry - e0) + (n_exit - x0)), 32'd0);
`endif

    // Totals and exclusivity over the whole run
    chk("total_entry", 32'(n_entry), 32'd2);
    chk("total_exit",  32'(n_exit),  32'd1);
    chk("pulse_excl",  32'(n_viol),  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_beam_direction_decoder
`default_nettype wire
